hazard_scoreboard: RTL

Hazard scoreboard for the ID stage. It tracks every in-flight register write from issue until writeback and stalls the instruction in ID when `fowarding_unit` cannot deliver the source operand in time. This covers load-use distance 1 and, optionally, a producer sitting in WB. The block is the issue-side counterpart of the EX/MEM and MEM/WB write information that the forwarding logic consumes: it produces and retires the same `rd` / write-enable stream.

---
 rtl/hazard_scoreboard_pkg.sv | 19 +
 rtl/hazard_scoreboard_if.sv | 36 +++
 rtl/hazard_scoreboard_entry.sv | 75 +++++++
 rtl/hazard_scoreboard.sv | 83 ++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int WAIT_W = 2;

    typedef logic [4:0]        reg_idx_t;
    typedef logic [WAIT_W-1:0] wait_t;

    // Cycles before the newest writer's result reaches the forwarding network
    localparam wait_t    LOAD_USE_WAIT = 2'd1;
    localparam wait_t    ALU_WAIT      = 2'd0;
    localparam reg_idx_t REG_ZERO      = 5'd0;

    // Forwarding delay loaded into an entry when its writer issues
    function automatic wait_t issue_wait(input logic mem_read);
        return mem_read ? LOAD_USE_WAIT : ALU_WAIT;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage / writeback signal bundle seen by the hazard scoreboard.
// master = pipeline control driving ID, flush and writeback; slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int NREGS = 32
);
    import hazard_scoreboard_pkg::*;

    logic             id_valid;
    reg_idx_t         id_rs;
    reg_idx_t         id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    reg_idx_t         id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_flush;
    logic             MEM_WB_reg_write_enable;
    reg_idx_t         MEM_WB_rd;
    logic             stall;
    logic [NREGS-1:0] pending_mask;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, ex_flush,
               MEM_WB_reg_write_enable, MEM_WB_rd,
        input  stall, pending_mask
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, ex_flush,
               MEM_WB_reg_write_enable, MEM_WB_rd,
        output stall, pending_mask
    );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One architectural register's scoreboard slot: in-flight writer count and
// cycles until the newest writer can be forwarded.
module scoreboard_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int IDX   = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc_i,
    input  wait_t reload_i,
    input  logic  dec_wb_i,
    input  logic  dec_flush_i,
    output logic  busy_o,
    output logic  ready_o,
    output logic  single_o
);

    logic [CNT_W-1:0] count_q, count_d;
    wait_t            wait_q, wait_d;
    logic             overflow;

    // Next count/wait: issue and writeback cancel; flush stacks on writeback
    always_comb begin
        count_d  = count_q;
        wait_d   = wait_q;
        overflow = 1'b0;
        if (inc_i && !dec_wb_i) begin
            if (count_q == '1) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (!inc_i && dec_wb_i && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
        if (dec_flush_i && count_d != '0) begin
            count_d = count_d - CNT_W'(1);
        end

        if (inc_i) begin
            wait_d = reload_i;
        end else if (dec_flush_i && count_d == '0) begin
            wait_d = '0;
        end else if (wait_q != '0) begin
            wait_d = wait_q - wait_t'(1);
        end
    end

    // Slot state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

`ifndef SYNTHESIS
    // A fourth writer cannot exist in a 5-stage pipeline; flag it loudly
    always_ff @(posedge clk) begin
        if (!rst && overflow) begin
            $display("ERROR: hazard_scoreboard r%0d in-flight counter overflow at %0t", IDX, $time);
        end
    end
`endif

    assign busy_o   = (count_q != '0);
    assign ready_o  = (wait_q == '0);
    assign single_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight register writes from issue to
// writeback and stalls ID when forwarding cannot supply a source in time.
// Optional feature macro: LAPIDO_RF_BYPASS_EN (write-before-read register file,
// so a source whose last writer is in WB this cycle needs no stall).
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input logic clk,
    input logic rst,
    hazard_scoreboard_if.slave sb
);

    logic             issue;
    reg_idx_t         ex_rd_q, ex_rd_d;
    logic             ex_wr_q, ex_wr_d;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] ready;
    logic [NREGS-1:0] single;
    logic             wb_last_rs, wb_last_rt;
    logic             hazard_rs, hazard_rt;

    assign issue = sb.id_valid & ~sb.stall & ~sb.ex_flush;

    assign busy[0]   = 1'b0;
    assign ready[0]  = 1'b1;
    assign single[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        scoreboard_entry #(
            .CNT_W (CNT_W),
            .IDX   (r)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (issue & sb.id_reg_write & (sb.id_rd == reg_idx_t'(r))),
            .reload_i    (issue_wait(sb.id_mem_read)),
            .dec_wb_i    (sb.MEM_WB_reg_write_enable & (sb.MEM_WB_rd == reg_idx_t'(r))),
            .dec_flush_i (sb.ex_flush & ex_wr_q & (ex_rd_q == reg_idx_t'(r))),
            .busy_o      (busy[r]),
            .ready_o     (ready[r]),
            .single_o    (single[r])
        );
    end

    // Mirror of the ID/EX destination so a flush can retire its count
    always_comb begin
        ex_rd_d = sb.id_rd;
        ex_wr_d = sb.id_reg_write & issue;
    end

    // EX tracking register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd_q <= REG_ZERO;
            ex_wr_q <= 1'b0;
        end else begin
            ex_rd_q <= ex_rd_d;
            ex_wr_q <= ex_wr_d;
        end
    end

    // Source hazard decode and stall OR-tree
    always_comb begin
`ifdef LAPIDO_RF_BYPASS_EN
        wb_last_rs = 1'b0;
        wb_last_rt = 1'b0;
`else
        wb_last_rs = sb.MEM_WB_reg_write_enable & (sb.MEM_WB_rd == sb.id_rs) & single[sb.id_rs];
        wb_last_rt = sb.MEM_WB_reg_write_enable & (sb.MEM_WB_rd == sb.id_rt) & single[sb.id_rt];
`endif
        hazard_rs = (sb.id_rs != REG_ZERO) & sb.id_uses_rs & busy[sb.id_rs]
                  & (~ready[sb.id_rs] | wb_last_rs);
        hazard_rt = (sb.id_rt != REG_ZERO) & sb.id_uses_rt & busy[sb.id_rt]
                  & (~ready[sb.id_rt] | wb_last_rt);
    end

    assign sb.stall        = sb.id_valid & (hazard_rs | hazard_rt);
    assign sb.pending_mask = busy;

endmodule
